// File: rtl/seq_detect_param.sv
// seq_detect_param: run-time-programmable Mealy serial pattern detector with overlap select.
// Optional saturating match counter is compiled in with `define SEQ_DET_CNT_EN.
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             x,
  output logic             y,
  input  logic             mode_ovl,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int FW = $clog2(PAT_W);
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-2:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [PAT_W-1:0] w_cat;
  logic             w_full;
  logic             w_match;
  assign w_cat   = {r_hist, x};
  assign w_full  = (r_fill == FW'(PAT_W - 1));
  assign w_match = en & ~pat_ld & w_full & (w_cat == r_pat);
  assign y       = w_match & ~clr;
  // Non-overlapping mode consumes the matched bits by restarting the fill count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pat  <= PAT_RST;
      r_hist <= '0;
      r_fill <= '0;
    end else if (pat_ld) begin
      r_pat  <= pat_in;
      r_fill <= '0;
    end else if (en) begin
      r_hist <= w_cat[PAT_W-2:0];
      r_fill <= (w_match & ~mode_ovl) ? '0 : w_full ? r_fill : r_fill + 1'b1;
    end
  end
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;
  assign w_sat = &r_cnt;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_cnt <= '0;
    else     r_cnt <= cnt_clr ? '0 : (w_match & ~w_sat) ? r_cnt + 1'b1 : r_cnt;
  end
  assign match_cnt = r_cnt;
  assign cnt_sat   = w_sat;
`else
  logic w_unused;
  assign w_unused  = cnt_clr;
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: randomized and directed checks of seq_detect_param against a queue-based model.
// Counter expectations follow `SEQ_DET_CNT_EN; a second instance uses CNT_W=2 for saturation.
module tb_seq_detect_param;
  localparam int PAT_W = 4;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic clr, en, x, mode_ovl, pat_ld, cnt_clr;
  logic [3:0] pat_in;
  logic y, y2, cnt_sat, cnt_sat2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  int n_cmp = 0;
  int n_fail = 0;
  bit q[$];
  int since;
  logic [3:0] m_pat;
  int m_c8, m_c2;
  logic obs_y, obs_y2, exp_y;

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .en(en), .x(x), .y(y), .mode_ovl(mode_ovl), .pat_ld(pat_ld),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .match_cnt(match_cnt), .cnt_sat(cnt_sat));
  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .en(en), .x(x), .y(y2), .mode_ovl(mode_ovl), .pat_ld(pat_ld),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2));

  initial forever #5 clk = ~clk;

  function automatic bit model_match(input bit e, input bit l, input bit xx);
    if (!e || l || since < PAT_W - 1) return 1'b0;
    if (xx != m_pat[0]) return 1'b0;
    for (int i = 1; i < PAT_W; i++)
      if (q[q.size() - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    q.delete();
    since = 0;
    m_pat = 4'b1011;
    m_c8 = 0;
    m_c2 = 0;
  endfunction

  task automatic cyc(input bit e, input bit xx, input bit l, input logic [3:0] p, input bit o, input bit c);
    bit m;
    en = e; x = xx; pat_ld = l; pat_in = p; mode_ovl = o; cnt_clr = c;
    @(negedge clk);
    obs_y = y;
    obs_y2 = y2;
    m = model_match(e, l, xx);
    exp_y = m;
    @(posedge clk);
    if (l) begin
      m_pat = p;
      since = 0;
    end else if (e) begin
      q.push_back(xx);
      if (q.size() > 32) void'(q.pop_front());
      since = (m && !o) ? 0 : since + 1;
    end
    if (c) begin
      m_c8 = 0;
      m_c2 = 0;
    end else if (m) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3) m_c2++;
    end
    #1;
  endtask

  task automatic do_reset();
    en = 0; x = 0; pat_ld = 0; cnt_clr = 0; mode_ovl = 0; pat_in = 0;
    clr = 1;
    #2;
    clr = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1; x = 1; pat_ld = 0; cnt_clr = 0; mode_ovl = 1; pat_in = 0;
    clr = 1;
    #1;
    n_cmp++; if (y !== 1'b0) begin n_fail++; $display("FAIL reset_y: got %b want 0", y); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
    n_cmp++; if (cnt_sat !== 1'b0 || cnt_sat2 !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b/%b want 0/0", cnt_sat, cnt_sat2); end
    @(posedge clk);
    #1;
    clr = 0;
    model_reset();
  endtask

  task automatic test_overlap();
    bit s[7] = '{1, 0, 1, 1, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1, s[i], 0, 0, 1, 0);
      n_cmp++;
      if (obs_y !== (i == 3 || i == 6)) begin n_fail++; $display("FAIL overlap bit%0d: y=%b want %b", i + 1, obs_y, (i == 3 || i == 6)); end
    end
    n_cmp++;
    if (match_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin n_fail++; $display("FAIL overlap_cnt: got %0d want %0d", match_cnt, CNT_EN ? 2 : 0); end
  endtask

  task automatic test_nonoverlap();
    bit s[11] = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(1, s[i], 0, 0, 0, 0);
      n_cmp++;
      if (obs_y !== (i == 3 || i == 10)) begin n_fail++; $display("FAIL nonoverlap bit%0d: y=%b want %b", i + 1, obs_y, (i == 3 || i == 10)); end
    end
  endtask

  task automatic test_enable_gaps();
    bit ev[9] = '{1, 0, 0, 1, 0, 1, 0, 0, 1};
    bit xv[9] = '{1, 0, 1, 0, 1, 1, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(ev[i], xv[i], 0, 0, 0, 0);
      n_cmp++;
      if (obs_y !== (i == 8)) begin n_fail++; $display("FAIL gaps cyc%0d: y=%b want %b", i, obs_y, (i == 8)); end
    end
  endtask

  task automatic test_pattern_load();
    bit a[3] = '{1, 0, 1};
    bit b[4] = '{0, 1, 1, 0};
    bit c[4] = '{1, 0, 1, 1};
    do_reset();
    foreach (a[i]) cyc(1, a[i], 0, 0, 1, 0);
    cyc(1, 1, 1, 4'b0110, 1, 0);
    n_cmp++; if (obs_y !== 1'b0) begin n_fail++; $display("FAIL load_cycle: y=%b want 0", obs_y); end
    foreach (b[i]) begin
      cyc(1, b[i], 0, 0, 1, 0);
      n_cmp++;
      if (obs_y !== (i == 3)) begin n_fail++; $display("FAIL load_new bit%0d: y=%b want %b", i, obs_y, (i == 3)); end
    end
    foreach (c[i]) begin
      cyc(1, c[i], 0, 0, 1, 0);
      n_cmp++;
      if (obs_y !== 1'b0) begin n_fail++; $display("FAIL load_old bit%0d: y=%b want 0", i, obs_y); end
    end
  endtask

  task automatic test_reset_mid();
    bit a[3] = '{1, 0, 1};
    bit b[3] = '{0, 1, 1};
    do_reset();
    foreach (a[i]) cyc(1, a[i], 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 0);
    en = 1; x = 1;
    #2;
    clr = 1;
    #1;
    n_cmp++; if (y !== 1'b0) begin n_fail++; $display("FAIL midreset_y_during: y=%b want 0", y); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL midreset_cnt: got %0d want 0", match_cnt); end
    #1;
    clr = 0;
    model_reset();
    foreach (a[i]) cyc(1, a[i], 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 0);
    n_cmp++; if (obs_y !== 1'b1) begin n_fail++; $display("FAIL midreset_refill: y=%b want 1", obs_y); end
    do_reset();
    foreach (a[i]) cyc(1, a[i], 0, 0, 1, 0);
    clr = 1;
    #2;
    clr = 0;
    model_reset();
    cyc(1, 1, 0, 0, 1, 0);
    n_cmp++; if (obs_y !== 1'b0) begin n_fail++; $display("FAIL midreset_first: y=%b want 0", obs_y); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL midreset_cnt2: got %0d want 0", match_cnt); end
    foreach (b[i]) begin
      cyc(1, b[i], 0, 0, 1, 0);
      n_cmp++;
      if (obs_y !== (i == 2)) begin n_fail++; $display("FAIL midreset_tail bit%0d: y=%b want %b", i, obs_y, (i == 2)); end
    end
  endtask

  task automatic test_saturation();
    bit s[3] = '{0, 1, 1};
    bit a[4] = '{1, 0, 1, 1};
    do_reset();
    foreach (a[i]) cyc(1, a[i], 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) foreach (s[i]) cyc(1, s[i], 0, 0, 1, 0);
    n_cmp++; if (match_cnt2 !== (CNT_EN ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL sat_cnt2: got %0d want %0d", match_cnt2, CNT_EN ? 3 : 0); end
    n_cmp++; if (cnt_sat2 !== CNT_EN) begin n_fail++; $display("FAIL sat_flag2: got %b want %b", cnt_sat2, CNT_EN); end
    n_cmp++; if (match_cnt !== (CNT_EN ? 8'd5 : 8'd0)) begin n_fail++; $display("FAIL sat_cnt8: got %0d want %0d", match_cnt, CNT_EN ? 5 : 0); end
    n_cmp++; if (cnt_sat !== 1'b0) begin n_fail++; $display("FAIL sat_flag8: got %b want 0", cnt_sat); end
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 1);
    n_cmp++; if (obs_y !== 1'b1) begin n_fail++; $display("FAIL satclr_y: y=%b want 1", obs_y); end
    n_cmp++; if (match_cnt2 !== 2'd0 || cnt_sat2 !== 1'b0) begin n_fail++; $display("FAIL satclr_cnt2: got %0d/%b want 0/0", match_cnt2, cnt_sat2); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL satclr_cnt8: got %0d want 0", match_cnt); end
  endtask

  task automatic test_random();
    bit e, xx, l, o, c;
    logic [3:0] p;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 3) != 0);
      xx = $urandom_range(0, 1);
      l = ($urandom_range(0, 39) == 0);
      p = 4'($urandom_range(0, 15));
      o = (i < 300) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 79) == 0);
      cyc(e, xx, l, p, o, c);
      n_cmp++; if (obs_y !== exp_y || obs_y2 !== exp_y) begin n_fail++; $display("FAIL rand_y cyc%0d: y=%b y2=%b want %b", i, obs_y, obs_y2, exp_y); end
      n_cmp++; if (match_cnt !== (CNT_EN ? 8'(m_c8) : 8'd0)) begin n_fail++; $display("FAIL rand_cnt8 cyc%0d: got %0d want %0d", i, match_cnt, CNT_EN ? m_c8 : 0); end
      n_cmp++; if (match_cnt2 !== (CNT_EN ? 2'(m_c2) : 2'd0) || cnt_sat2 !== (CNT_EN && m_c2 == 3)) begin n_fail++; $display("FAIL rand_cnt2 cyc%0d: got %0d/%b want %0d", i, match_cnt2, cnt_sat2, CNT_EN ? m_c2 : 0); end
      n_cmp++; if (cnt_sat !== (CNT_EN && m_c8 == 255)) begin n_fail++; $display("FAIL rand_sat8 cyc%0d: got %b", i, cnt_sat); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_enable_gaps();
    test_pattern_load();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Mealy serial sequence detector. It watches a 1-bit serial input `x` qualified by `en`, and asserts `y` combinationally in the same cycle that the last bit of a run-time-programmable `PAT_W`-bit pattern arrives. Overlapping and non-overlapping detection are selectable at run time, and an optional saturating match counter can be compiled in. It is the generalised successor to the fixed-pattern FSM sequence detector in the FSM library, and it drops into the same serial-stream monitoring slots.

## Interface
Parameters:
- `PAT_W`, default 4: pattern length in bits; legal range 2..32.
- `PAT_RST`, default 4'b1011: pattern loaded at reset; `PAT_W` bits wide.
- `CNT_W`, default 8: match counter width; legal range 1..32.

Ports:
- `clk`  in  1: single clock; all flops are rising-edge.
- `clr`  in  1: asynchronous, active-high reset.
- `en`  in  1: `x` is valid this cycle.
- `x`  in  1: serial data bit; the newest bit is the pattern LSB.
- `y`  out  1: Mealy match output, combinational.
- `mode_ovl`  in  1: 1 selects overlapping detection, 0 selects non-overlapping.
- `pat_ld`  in  1: load a new pattern.
- `pat_in`  in  `PAT_W`: new pattern value.
- `cnt_clr`  in  1: synchronous clear of the match counter.
- `match_cnt`  out  `CNT_W`: number of matches seen.
- `cnt_sat`  out  1: match counter is saturated.

## Operation
Internal state:
- `pat`: pattern register, `PAT_W` bits.
- `hist`: last `PAT_W-1` accepted bits, newest at bit 0.
- `fill`: count of accepted bits, 0..`PAT_W-1`; saturates at `PAT_W-1`.

Match rule:
- Condition: `match = en & ~pat_ld & (fill == PAT_W-1) & ({hist, x} == pat)`.
- Output: `y = match`.

Per-cycle update, in priority order:
1. `pat_ld=1`:
   - `pat <= pat_in`, `fill <= 0`, `hist` unchanged.
   - `x` is ignored and `y=0`, even if `en=1`.
2. `en=1`:
   - `hist <= {hist[PAT_W-3:0], x}`.
   - If `match & ~mode_ovl`: `fill <= 0` (the matched bits are consumed).
   - Otherwise: `fill <= min(fill+1, PAT_W-1)`.
3. `en=0`: all state holds and `y=0`.

Further rules:
- `mode_ovl` is sampled every cycle and can change between matches without a flush.
- Match counter (only when the counter macro is defined):
  - `cnt_clr=1`: next value is 0. This wins over a simultaneous match.
  - Else on `match`: increment unless already at `2^CNT_W-1`; at that value it holds.
  - `cnt_sat = (match_cnt == 2^CNT_W-1)`.

Reset (`clr=1`, asynchronous):
- `pat <= PAT_RST`, `hist <= 0`, `fill <= 0`, counter <= 0.
- `y` is forced to 0 while `clr` is high.
- Reset asserted mid-sequence discards all partial progress.

## Timing
- `y` has zero latency: it is valid in the same cycle as the final pattern bit on `x`/`en`.
- `y` is combinational from `x`, `en`, `pat_ld` and state. Downstream logic must register it.
- `match_cnt` and `cnt_sat` update on the clock edge that ends the matching cycle, so they are visible one cycle after `y`.
- After `pat_ld`, the earliest possible match is the `PAT_W`-th accepted bit after the load cycle.
- After reset deassertion, the earliest possible match is the `PAT_W`-th accepted bit.
- Output reset values: `y=0`, `match_cnt=0`, `cnt_sat=0`.

## Configuration
- Macro `SEQ_DET_CNT_EN`.
- Defined: the match counter, `cnt_clr` handling and `cnt_sat` are implemented as described in Operation.
- Undefined:
  - No counter flops are built.
  - `match_cnt` is tied to 0 and `cnt_sat` is tied to 0.
  - `cnt_clr` is ignored.
  - Ports are unchanged, so instances compile either way.
  - Detection behaviour is identical.

## Test plan
All scenarios use `PAT_W=4`, `PAT_RST=1011`, `en=1` except where stated, and bits listed oldest first.
1. Overlap: `mode_ovl=1`, stream 1,0,1,1,0,1,1 -> `y=1` on bits 4 and 7 only. With the macro defined, `match_cnt=2`.
2. Non-overlap: `mode_ovl=0`, stream 1,0,1,1,0,1,1,1,0,1,1 -> `y=1` on bits 4 and 11 only; no match on bit 7.
3. Enable gaps: stream 1,0,1,1 with `en=0` cycles inserted between bits, and `x` toggling during those cycles -> `y=1` exactly once, on the cycle carrying the fourth accepted bit.
4. Pattern load:
   - After bits 1,0,1, pulse `pat_ld` with `pat_in=0110` while `en=1`, `x=1` -> `y=0` that cycle.
   - Then feed 0,1,1,0 -> `y=1` on the final 0.
   - Old pattern 1011 does not match afterward.
5. Reset mid-sequence: feed 1,0,1, assert `clr` asynchronously between edges, release, feed 1 -> `y=0`, `match_cnt=0`. Then feed 0,1,1 -> `y=1` on the last 1.
6. Counter saturation (`SEQ_DET_CNT_EN` defined, `CNT_W=2`, `mode_ovl=1`):
   - 5 matches -> `match_cnt=3`, `cnt_sat=1`.
   - Then `cnt_clr` on the same cycle as a match -> `match_cnt=0`, `cnt_sat=0`.
